eth_frame_detector_log_mux: RTL and testbench
=============================================

// Module: eth_frame_detector_log_mux
// PURPOSE
//  Merges the two per-interface log streams of the frame detector (M_AXIS_LOG_A, M_AXIS_LOG_B) into one
//  AXI4-Stream feeding the log DMA/FIFO. Arbitration is packet-granular round-robin: a log record (tlast-framed)
//  is never interleaved. Output is registered through a skid buffer; per-source record counters go to the AXI regs.
// PARAMETERS
//  C_AXIS_LOG_WIDTH  64  data width of all log streams, bits
//  C_COUNTER_WIDTH   32  width of per-source record counters (wrap-around)
// PORTS
//  clk                  in   1                   single clock (s_axi_clk domain)
//  rst_n                in   1                   synchronous active-low reset
//  srst                 in   1                   synchronous soft reset, same effect as rst_n=0
//  s_axis_log_a_tdata   in   C_AXIS_LOG_WIDTH    log beats from loop A
//  s_axis_log_a_tlast   in   1                   last beat of record A
//  s_axis_log_a_tvalid  in   1
//  s_axis_log_a_tready  out  1
//  s_axis_log_b_tdata   in   C_AXIS_LOG_WIDTH    log beats from loop B
//  s_axis_log_b_tlast   in   1
//  s_axis_log_b_tvalid  in   1
//  s_axis_log_b_tready  out  1
//  m_axis_log_tdata     out  C_AXIS_LOG_WIDTH    merged log stream
//  m_axis_log_tdest     out  1                   source of current beat: 0=A, 1=B
//  m_axis_log_tlast     out  1
//  m_axis_log_tvalid    out  1
//  m_axis_log_tready    in   1
//  record_count_a       out  C_COUNTER_WIDTH     records (tlast beats) forwarded from A
//  record_count_b       out  C_COUNTER_WIDTH     records forwarded from B
// BEHAVIOUR
//  - Reset (rst_n=0 or srst=1, sampled on clk): state=IDLE, priority=A, skid buffer empty; all outputs 0
//    (tvalid, tready, tdata, tdest, tlast, counters). srst mid-record: record truncated, no tlast emitted.
//  - FSM states IDLE, XFER_A, XFER_B:
//    IDLE: A valid only -> XFER_A; B valid only -> XFER_B; both -> side holding priority. No beat taken in IDLE.
//    XFER_x: s_axis_log_x_tready = skid buffer can accept; other tready=0. On accepted beat with tlast:
//    priority <= other side, state <= IDLE, record_count_x += 1 (wraps 2^W-1 -> 0).
//  - Min. 1 idle cycle between records (IDLE decision cycle); max throughput 1 beat/clk within a record.
//  - Latency: input beat accepted at cycle N appears on m_axis_log at N+1 (registered).
//  - Skid buffer: 2 entries; s tready is registered (not combinational from m_axis_log_tready); full -> tready=0
//    next cycle, no beat lost or duplicated; tdata/tdest/tlast held stable while tvalid & ~tready.
//  - Input tvalid dropping mid-record: FSM stays in XFER_x, waits; no arbitration until tlast.
//  - Counter update and arbitration same cycle: counter reflects record at the cycle after its tlast accept.
// STRUCTURE
//  - Package eth_frame_detector_log_mux_pkg: typedef enum logic [1:0] {ST_IDLE, ST_XFER_A, ST_XFER_B} log_mux_state_t;
//    localparam SRC_A=1'b0, SRC_B=1'b1.
//  - One sub-module: eth_log_skid_buffer #(WIDTH) (2-entry register slice, registered ready); payload
//    {tdest, tlast, tdata}. Arbiter FSM + counters in top.
// TESTING
//  1. Reset: rst_n=0 2 clk with both tvalid=1 -> all outputs 0, both tready=0; after release A granted first.
//  2. Contention: A and B each present 3-beat records continuously, tready=1 -> output order A,B,A,B, tdest
//     alternates per record, no interleave, record_count_a=record_count_b=2 after 4 records.
//  3. Backpressure: 8-beat B record, m_axis_log_tready toggles 1,0,0,1... -> 8 beats out in order, data
//     0x0..0x7 intact, tdata stable during stalls, tlast only on beat 7.
//  4. Gapped source: A drops tvalid for 5 clk mid-record while B valid -> B not granted until A tlast accepted.
//  5. Soft reset: srst=1 at beat 2 of a 4-beat A record -> next clk tvalid=0, counters 0, priority A;
//     fresh B record afterwards passes whole with tdest=1.
//  6. Wrap: C_COUNTER_WIDTH=4, 17 single-beat A records -> record_count_a=1.

Source files
------------

// File: rtl/eth_frame_detector_log_mux_pkg.sv
// Shared types for the frame-detector log stream merger.
package eth_frame_detector_log_mux_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_XFER_A, ST_XFER_B} log_mux_state_t;
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;
endpackage

// File: rtl/eth_log_skid_buffer.sv
// Two-entry register slice: output register plus one skid entry, ready is registered.
module eth_log_skid_buffer #(
    parameter int WIDTH = 66
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);
    logic [WIDTH-1:0] out_q, out_d, skid_q, skid_d;
    logic             out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, rdy_q;
    logic             push;

    assign push = s_valid_i & rdy_q;

    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!out_vld_q || m_ready_i) begin
            // Skid entry is always older than anything arriving now
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = push;
                if (push) out_d = s_data_i;
            end
        end else if (push) begin
            skid_d     = s_data_i;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= ~skid_vld_d;
        end
    end

    assign s_ready_o = rdy_q;
    assign m_data_o  = out_q;
    assign m_valid_o = out_vld_q;
endmodule

// File: rtl/eth_frame_detector_log_mux.sv
// Packet-granular round-robin merge of log streams A and B into one registered AXI4-Stream.
module eth_frame_detector_log_mux
    import eth_frame_detector_log_mux_pkg::*;
#(
    parameter int C_AXIS_LOG_WIDTH = 64,
    parameter int C_COUNTER_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        srst,
    input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_a_tdata,
    input  logic                        s_axis_log_a_tlast,
    input  logic                        s_axis_log_a_tvalid,
    output logic                        s_axis_log_a_tready,
    input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_b_tdata,
    input  logic                        s_axis_log_b_tlast,
    input  logic                        s_axis_log_b_tvalid,
    output logic                        s_axis_log_b_tready,
    output logic [C_AXIS_LOG_WIDTH-1:0] m_axis_log_tdata,
    output logic                        m_axis_log_tdest,
    output logic                        m_axis_log_tlast,
    output logic                        m_axis_log_tvalid,
    input  logic                        m_axis_log_tready,
    output logic [C_COUNTER_WIDTH-1:0]  record_count_a,
    output logic [C_COUNTER_WIDTH-1:0]  record_count_b
);
    localparam int PW = C_AXIS_LOG_WIDTH + 2;

    log_mux_state_t             state_q, state_d;
    logic                       prio_q, prio_d;
    logic [C_COUNTER_WIDTH-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic                       rst_eff_n, sb_ready, sb_valid, a_done, b_done;
    logic [PW-1:0]              sb_in, sb_out;

    assign rst_eff_n = rst_n & ~srst;

    always_ff @(posedge clk) begin
        if (!rst_eff_n) begin
            state_q <= ST_IDLE;
            prio_q  <= SRC_A;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign a_done = s_axis_log_a_tvalid & s_axis_log_a_tready & s_axis_log_a_tlast;
    assign b_done = s_axis_log_b_tvalid & s_axis_log_b_tready & s_axis_log_b_tlast;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (s_axis_log_a_tvalid && (!s_axis_log_b_tvalid || prio_q == SRC_A))
                    state_d = ST_XFER_A;
                else if (s_axis_log_b_tvalid)
                    state_d = ST_XFER_B;
            end
            ST_XFER_A: if (a_done) begin
                state_d = ST_IDLE;
                prio_d  = SRC_B;
                cnt_a_d = cnt_a_q + 1'b1;
            end
            ST_XFER_B: if (b_done) begin
                state_d = ST_IDLE;
                prio_d  = SRC_A;
                cnt_b_d = cnt_b_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Only the granted source sees the buffer's ready; the other is held off until tlast
    always_comb begin
        s_axis_log_a_tready = (state_q == ST_XFER_A) & sb_ready;
        s_axis_log_b_tready = (state_q == ST_XFER_B) & sb_ready;
        sb_valid = ((state_q == ST_XFER_A) & s_axis_log_a_tvalid) |
                   ((state_q == ST_XFER_B) & s_axis_log_b_tvalid);
        sb_in = (state_q == ST_XFER_B) ?
                {SRC_B, s_axis_log_b_tlast, s_axis_log_b_tdata} :
                {SRC_A, s_axis_log_a_tlast, s_axis_log_a_tdata};
    end

    eth_log_skid_buffer #(.WIDTH(PW)) u_skid (
        .clk_i     (clk),
        .rst_ni    (rst_eff_n),
        .s_data_i  (sb_in),
        .s_valid_i (sb_valid),
        .s_ready_o (sb_ready),
        .m_data_o  (sb_out),
        .m_valid_o (m_axis_log_tvalid),
        .m_ready_i (m_axis_log_tready)
    );

    assign {m_axis_log_tdest, m_axis_log_tlast, m_axis_log_tdata} = sb_out;
    assign record_count_a = cnt_a_q;
    assign record_count_b = cnt_b_q;
endmodule

// File: tb/tb_eth_frame_detector_log_mux.sv
// Directed bench for the log stream merger with a per-source scoreboard and record-order queue.
module tb_eth_frame_detector_log_mux;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n, srst;
    logic [63:0]   a_data, b_data, m_data;
    logic          a_last, a_valid, a_ready, b_last, b_valid, b_ready;
    logic          m_dest, m_last, m_valid, m_ready;
    logic [CW-1:0] rc_a, rc_b;

    int checks = 0;
    int errors = 0;
    int cnt_a  = 0;
    int cnt_b  = 0;
    logic [64:0] qa[$];
    logic [64:0] qb[$];
    logic        qrec[$];

    always #5 clk = ~clk;

    eth_frame_detector_log_mux #(.C_AXIS_LOG_WIDTH(64), .C_COUNTER_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .srst(srst),
        .s_axis_log_a_tdata(a_data), .s_axis_log_a_tlast(a_last),
        .s_axis_log_a_tvalid(a_valid), .s_axis_log_a_tready(a_ready),
        .s_axis_log_b_tdata(b_data), .s_axis_log_b_tlast(b_last),
        .s_axis_log_b_tvalid(b_valid), .s_axis_log_b_tready(b_ready),
        .m_axis_log_tdata(m_data), .m_axis_log_tdest(m_dest), .m_axis_log_tlast(m_last),
        .m_axis_log_tvalid(m_valid), .m_axis_log_tready(m_ready),
        .record_count_a(rc_a), .record_count_b(rc_b)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        checks++;
        errors++;
        $display("FAIL %s observed=timeout/empty expected=event", tag);
    endtask

    // Every valid output cycle must show the oldest outstanding beat of the expected source
    always @(negedge clk) begin
        if (m_valid) begin
            if (qrec.size() == 0) fail_now("unexpected_record");
            else if ((qrec[0] ? qb.size() : qa.size()) == 0) fail_now("unexpected_beat");
            else begin
                logic        src;
                logic [64:0] exp;
                src = qrec[0];
                exp = src ? qb[0] : qa[0];
                check("out_beat", {m_dest, m_last, m_data}, {src, exp});
                if (m_ready) begin
                    if (src) void'(qb.pop_front()); else void'(qa.pop_front());
                    if (exp[64]) void'(qrec.pop_front());
                end
            end
        end
    end

    // Present one record; gap drops valid before beat gap_at, abort pulses srst on beat abort_at
    task automatic send(input bit src, input int n, input logic [63:0] base,
                        input int gap_at, input int gap_len, input int abort_at);
        for (int k = 0; k < n; k++) begin
            bit hs;
            int budget;
            if (k == gap_at) begin
                if (src) b_valid = 1'b0; else a_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    check("gap_other_ready", src ? a_ready : b_ready, 1'b0);
                    @(posedge clk); #1;
                end
            end
            if (src) begin b_valid = 1'b1; b_data = base + k; b_last = (k == n - 1); end
            else     begin a_valid = 1'b1; a_data = base + k; a_last = (k == n - 1); end
            if (k == abort_at) begin
                srst = 1'b1;
                @(posedge clk); #1;
                srst = 1'b0;
                if (src) b_valid = 1'b0; else a_valid = 1'b0;
                return;
            end
            if (src) qb.push_back({k == n - 1, base + k});
            else     qa.push_back({k == n - 1, base + k});
            hs = 1'b0;
            budget = 0;
            while (!hs && budget < 300) begin
                @(negedge clk);
                hs = src ? b_ready : a_ready;
                @(posedge clk); #1;
                budget++;
            end
            if (!hs) begin
                fail_now("input_handshake");
                return;
            end
        end
        if (src) b_valid = 1'b0; else a_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while ((qrec.size() != 0 || qa.size() != 0 || qb.size() != 0 || m_valid) && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 300) fail_now("drain");
    endtask

    task automatic check_counts();
        @(negedge clk);
        check("record_count_a", rc_a, cnt_a[CW-1:0]);
        check("record_count_b", rc_b, cnt_b[CW-1:0]);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; srst = 1'b0; m_ready = 1'b1;
        a_valid = 1'b1; a_data = 64'hA000; a_last = 1'b0;
        b_valid = 1'b1; b_data = 64'hB000; b_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_ready", {m_valid, a_ready, b_ready}, 3'b000);
        check("rst_payload", {m_dest, m_last, m_data}, 66'h0);
        check("rst_counts", {rc_a, rc_b}, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Contention: A first after reset, then strict alternation per record
        qrec.push_back(1'b0); qrec.push_back(1'b1); qrec.push_back(1'b0); qrec.push_back(1'b1);
        fork
            begin send(1'b0, 3, 64'hA000, -1, 0, -1); send(1'b0, 3, 64'hA010, -1, 0, -1); end
            begin send(1'b1, 3, 64'hB000, -1, 0, -1); send(1'b1, 3, 64'hB010, -1, 0, -1); end
        join
        drain();
        cnt_a += 2; cnt_b += 2;
        check_counts();

        // Backpressure on an 8-beat B record
        qrec.push_back(1'b1);
        fork
            send(1'b1, 8, 64'h0, -1, 0, -1);
            begin
                for (int i = 0; i < 30; i++) begin
                    m_ready = (i % 3 == 0);
                    @(posedge clk); #1;
                end
                m_ready = 1'b1;
            end
        join
        drain();
        cnt_b += 1;
        check_counts();

        // A pauses mid-record; B must wait for A's tlast
        qrec.push_back(1'b0); qrec.push_back(1'b1);
        fork
            send(1'b0, 4, 64'h4A0, 2, 5, -1);
            send(1'b1, 2, 64'h4B0, -1, 0, -1);
        join
        drain();
        cnt_a += 1; cnt_b += 1;
        check_counts();

        // Leave priority with B so the soft reset's priority restore is observable
        qrec.push_back(1'b0);
        send(1'b0, 1, 64'h4C0, -1, 0, -1);
        drain();
        cnt_a += 1;

        qrec.push_back(1'b0);
        send(1'b0, 4, 64'h50, -1, 0, 2);
        @(negedge clk);
        check("srst_valid_ready", {m_valid, a_ready, b_ready}, 3'b000);
        check("srst_counts", {rc_a, rc_b}, 8'h00);
        @(posedge clk); #1;
        qrec.delete(); qa.delete(); qb.delete();
        cnt_a = 0; cnt_b = 0;
        qrec.push_back(1'b0); qrec.push_back(1'b1);
        fork
            send(1'b0, 1, 64'h5A0, -1, 0, -1);
            send(1'b1, 3, 64'h5B0, -1, 0, -1);
        join
        drain();
        cnt_a += 1; cnt_b += 1;
        check_counts();

        // Counter wrap with a 4-bit counter
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int r = 0; r < 17; r++) begin
            qrec.push_back(1'b0);
            send(1'b0, 1, 64'h600 + r, -1, 0, -1);
            cnt_a = (cnt_a + 1) % (1 << CW);
        end
        drain();
        check_counts();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
